// File: rtl/parallel_to_serial_if.sv
// Parallel-side handshake bundle for parallel_to_serial.
//   DATA_IN   : parallel symbol offered by the producer
//   VALID_IN  : DATA_IN is valid
//   READY_OUT : serializer accepts DATA_IN at this edge when VALID_IN is high
// master = producer side, slave = serializer side.
interface parallel_to_serial_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] DATA_IN;
    logic             VALID_IN;
    logic             READY_OUT;

    modport master (output DATA_IN, output VALID_IN, input READY_OUT);
    modport slave  (input DATA_IN, input VALID_IN, output READY_OUT);
endinterface

// File: rtl/parallel_to_serial.sv
// Transmit end of a serial link: accepts parallel symbols over a valid/ready
// handshake into a one-entry buffer and shifts them out MSB first, one bit
// per clock. Gaps are filled with IDLE_SYM; after reset SYNC_SYMS idle
// symbols are sent before any data is accepted.
//   CLK          : clock, rising edge
//   RESET        : synchronous active-high reset
//   in_if        : parallel handshake (DATA_IN, VALID_IN, READY_OUT)
//   DATA_OUT     : serial bit, MSB of current symbol first
//   SYM_START    : high during the first bit of every symbol
//   SENDING_DATA : current symbol is user data rather than idle
module parallel_to_serial #(
    parameter int unsigned      WIDTH     = 10,
    parameter logic [WIDTH-1:0] IDLE_SYM  = 10'b0011111010,
    parameter int unsigned      SYNC_SYMS = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    parallel_to_serial_if.slave  in_if,
    output logic                 DATA_OUT,
    output logic                 SYM_START,
    output logic                 SENDING_DATA
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned SW = (SYNC_SYMS > 1) ? $clog2(SYNC_SYMS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_SYMS - 1);

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0] hold_q,       hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [SW-1:0]    sync_cnt_q,   sync_cnt_d;
    logic             sending_q,    sending_d;

    logic last;
    logic ready;
    logic accept;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_SYNC;
            shift_q      <= IDLE_SYM;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sync_cnt_q   <= '0;
            sending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sync_cnt_q   <= sync_cnt_d;
            sending_q    <= sending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d    = bit_cnt_q + 1'b1;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sync_cnt_d   = sync_cnt_q;
        sending_d    = sending_q;

        last = (bit_cnt_q == CNT_LAST);
        // At a symbol boundary the buffer drains, so it can refill at the same edge.
        ready  = (state_q == ST_RUN) && (!hold_valid_q || last);
        accept = in_if.VALID_IN && ready;

        if (!last) begin
            if (accept) begin
                hold_d       = in_if.DATA_IN;
                hold_valid_d = 1'b1;
            end
        end else begin
            bit_cnt_d = '0;
            if (hold_valid_q) begin
                shift_d   = hold_q;
                sending_d = 1'b1;
                if (accept) begin
                    hold_d = in_if.DATA_IN;
                end else begin
                    hold_valid_d = 1'b0;
                end
            end else if (accept) begin
                // Bypass: buffer empty, word goes straight into the shifter.
                shift_d   = in_if.DATA_IN;
                sending_d = 1'b1;
            end else begin
                shift_d   = IDLE_SYM;
                sending_d = 1'b0;
            end

            if (state_q == ST_SYNC) begin
                sync_cnt_d = sync_cnt_q + 1'b1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    assign in_if.READY_OUT = ready;
    assign DATA_OUT        = shift_q[WIDTH-1];
    assign SYM_START       = (bit_cnt_q == '0);
    assign SENDING_DATA    = sending_q;
endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;
    localparam int unsigned      W     = 10;
    localparam logic [W-1:0]     IDLE  = 10'b0011111010;
    localparam int unsigned      NSYNC = 2;

    logic CLK;
    logic RESET;
    logic DATA_OUT;
    logic SYM_START;
    logic SENDING_DATA;

    parallel_to_serial_if #(.WIDTH(W)) bus ();

    parallel_to_serial #(
        .WIDTH(W),
        .IDLE_SYM(IDLE),
        .SYNC_SYMS(NSYNC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .in_if(bus),
        .DATA_OUT(DATA_OUT),
        .SYM_START(SYM_START),
        .SENDING_DATA(SENDING_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: the link is a stream of whole symbols; a FIFO of words
    // waiting to be sent, the symbol on the wire, and the cycle count since reset.
    int           m_cyc;
    logic [W-1:0] m_cur;
    logic         m_data;
    logic [W-1:0] m_q[$];
    int           acc_cnt;
    int           dut_syms;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_cur  = IDLE;
        m_data = 1'b0;
        m_q.delete();
    endtask

    // One clock: check outputs at negedge, then advance the model across the edge.
    task automatic tick();
        int   t;
        logic exp_rdy;
        logic acc;
        @(negedge CLK);
        t       = m_cyc % W;
        exp_rdy = (m_cyc >= int'(NSYNC * W)) && ((m_q.size() == 0) || (t == W - 1));
        chk("data_out", DATA_OUT, m_cur[W-1-t]);
        chk("sym_start", SYM_START, (t == 0));
        chk("ready", bus.READY_OUT, exp_rdy);
        chk("sending", SENDING_DATA, m_data);
        if (SYM_START && SENDING_DATA) dut_syms++;
        acc = bus.VALID_IN && exp_rdy && !RESET;
        @(posedge CLK);
        if (RESET) begin
            model_reset();
        end else begin
            if (acc) begin
                m_q.push_back(bus.DATA_IN);
                acc_cnt++;
            end
            if (t == W - 1) begin
                if (m_q.size() > 0) begin
                    m_cur  = m_q.pop_front();
                    m_data = 1'b1;
                end else begin
                    m_cur  = IDLE;
                    m_data = 1'b0;
                end
            end
            m_cyc++;
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, DATA_OUT, IDLE[W-1]);
        chk({tag, "_start"}, SYM_START, 1'b1);
        chk({tag, "_ready"}, bus.READY_OUT, 1'b0);
        chk({tag, "_sending"}, SENDING_DATA, 1'b0);
    endtask

    task automatic do_reset();
        RESET        = 1'b1;
        bus.VALID_IN = 1'b0;
        tick();
        check_reset_state("reset");
        RESET = 1'b0;
    endtask

    initial begin
        int budget;
        RESET        = 1'b1;
        bus.VALID_IN = 1'b0;
        bus.DATA_IN  = '0;
        acc_cnt      = 0;
        dut_syms     = 0;
        @(posedge CLK);
        #1;
        model_reset();

        // Idle only: preamble then continuous comma symbols.
        do_reset();
        repeat (40) tick();

        // VALID held high from cycle 0: back-to-back data from cycle 30.
        do_reset();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 10'b1100000101;
        repeat (60) tick();
        bus.VALID_IN = 1'b0;

        // Bypass at LAST of cycle 29.
        do_reset();
        while (m_cyc < 29) tick();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 10'h2AA;
        tick();
        bus.VALID_IN = 1'b0;
        repeat (20) tick();

        // A mid-symbol at 22, B at the draining LAST edge of 29.
        do_reset();
        while (m_cyc < 22) tick();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 10'h3C3;
        tick();
        bus.VALID_IN = 1'b0;
        while (m_cyc < 29) tick();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 10'h0F0;
        tick();
        bus.VALID_IN = 1'b0;
        repeat (30) tick();

        // Reset mid-data-symbol; held word discarded.
        do_reset();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 10'b1100000101;
        while (m_cyc < 35) tick();
        RESET = 1'b1;
        tick();
        RESET        = 1'b0;
        bus.VALID_IN = 1'b0;
        check_reset_state("midreset");
        repeat (30) tick();

        // Random traffic: 1000 words, occasional IDLE_SYM as data.
        do_reset();
        acc_cnt  = 0;
        dut_syms = 0;
        budget   = 0;
        while (acc_cnt < 1000 && budget < 40000) begin
            bus.VALID_IN = ($urandom_range(3) != 0);
            bus.DATA_IN  = ($urandom_range(15) == 0) ? IDLE : W'($urandom);
            tick();
            budget++;
        end
        bus.VALID_IN = 1'b0;
        chk("rand_budget", acc_cnt, 1000);
        repeat (3 * W) tick();
        chk("rand_sent_once", dut_syms, acc_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

- Transmit end of the serial link whose receive end is `serial_to_parallel`.
- Accepts parallel symbols over a valid/ready handshake and holds one word in a one-entry buffer.
- Shifts each symbol out MSB first, one bit per `CLK`.
- Fills every gap with an idle/comma symbol so the receiver can keep word alignment; after reset it sends a fixed sync preamble of idle symbols before accepting any data.

## Interface
Parameters:
- `WIDTH`, 10: bits per symbol (≥ 2).
- `IDLE_SYM`, 10'b0011111010 (K28.5, RD-): symbol sent when no data is available.
- `SYNC_SYMS`, 2: idle symbols sent after reset before data is accepted (≥ 1).

Ports:
- `CLK`  in  1: single clock; all logic on rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `DATA_IN`  in  WIDTH: parallel symbol to send.
- `VALID_IN`  in  1: `DATA_IN` is valid.
- `READY_OUT`  out  1: block accepts `DATA_IN` at this edge if `VALID_IN`.
- `DATA_OUT`  out  1: serial bit, MSB of the current symbol first.
- `SYM_START`  out  1: high during the first bit of every symbol.
- `SENDING_DATA`  out  1: current symbol is user data, not idle.

## Operation
State:
- `SHIFT[WIDTH-1:0]`: current symbol.
- `BIT_CNT`: 0..WIDTH-1.
- `HOLD[WIDTH-1:0]`, `HOLD_VALID`: one-entry buffer.
- `SYNC_CNT`: preamble counter.
- FSM: `SYNC`, `RUN`.

Signal definitions:
- `DATA_OUT` = `SHIFT[WIDTH-1]`.
- `SYM_START` = (`BIT_CNT` == 0).
- `LAST` = (`BIT_CNT` == WIDTH-1).
- Accept = `VALID_IN` && `READY_OUT`.

`SYNC` state:
- `READY_OUT` = 0.
- Idle symbols only.
- `SYNC_CNT` increments at each `LAST` edge.
- At the `LAST` edge with `SYNC_CNT` == SYNC_SYMS-1, go to `RUN`.

`RUN` state:
- `READY_OUT` = !`HOLD_VALID` || `LAST`. Drain and fill may happen at the same edge.

Per edge, when not `LAST`:
- `SHIFT` <= {`SHIFT[WIDTH-2:0]`, 0}.
- `BIT_CNT`++.
- On accept: `HOLD` <= `DATA_IN`, `HOLD_VALID` <= 1.

Per edge, when `LAST` (symbol boundary), `BIT_CNT` <= 0 and the next symbol is chosen in priority order:
1. If `HOLD_VALID`: `SHIFT` <= `HOLD`, `SENDING_DATA` <= 1. If an accept happens at the same edge, `HOLD` <= `DATA_IN` (stays valid); otherwise `HOLD_VALID` <= 0.
2. Else on accept (bypass): `SHIFT` <= `DATA_IN`, `SENDING_DATA` <= 1, `HOLD` stays empty.
3. Else: `SHIFT` <= `IDLE_SYM`, `SENDING_DATA` <= 0.

Rules:
- Symbols are never truncated, reordered or duplicated.
- An accepted word is sent exactly once.
- `DATA_IN` values equal to `IDLE_SYM` are sent as data (`SENDING_DATA` = 1); no filtering.

## Timing
Reset (any edge with `RESET` = 1, including mid-symbol; an in-flight symbol and any held word are discarded):
- FSM = `SYNC`, `SYNC_CNT` = 0, `BIT_CNT` = 0.
- `SHIFT` = `IDLE_SYM`, `HOLD_VALID` = 0.
- Outputs: `DATA_OUT` = `IDLE_SYM[WIDTH-1]` (0 by default), `SYM_START` = 1, `READY_OUT` = 0, `SENDING_DATA` = 0.

Cycle numbering: cycle 0 is the first cycle with `RESET` low. Symbol n occupies cycles n·WIDTH .. n·WIDTH+WIDTH-1.

Latency:
- Word accepted at a `LAST` edge with `HOLD` empty: its MSB appears the next cycle.
- Word accepted mid-symbol: its MSB appears at the next symbol boundary (at most WIDTH-1 cycles later), provided `HOLD` was empty.

Throughput: one word per WIDTH cycles sustained. With `VALID_IN` held high, `READY_OUT` is high once per symbol, at `LAST` (after the first fill).

`SYNC` duration: `READY_OUT` first goes high at cycle SYNC_SYMS·WIDTH (cycle 20 with defaults).

## Test plan
- Reset, `VALID_IN` = 0 for 40 cycles -> `DATA_OUT` repeats 0011111010 every 10 cycles; `SYM_START` high at cycles 0, 10, 20, 30; `READY_OUT` 0 for cycles 0-19, 1 from 20; `SENDING_DATA` 0 throughout.
- `VALID_IN` = 1, `DATA_IN` = 10'b1100000101 held from cycle 0 -> first accept at edge ending cycle 20; cycles 30-39 carry 1100000101 with `SENDING_DATA` = 1; back-to-back copies follow with no idle gap.
- Accept 10'h2AA at `LAST` cycle 29 with `HOLD` empty (bypass) -> cycles 30-39 = 1010101010.
- Accept A = 10'h3C3 at cycle 22, then B = 10'h0F0 at cycle 29 -> A in cycles 30-39, B in 40-49, then idle from 50; `READY_OUT` stays high at 29 because the buffer drains at that edge.
- `RESET` pulsed at cycle 35, mid-data-symbol -> next cycle `DATA_OUT` = 0, `SYM_START` = 1, `READY_OUT` = 0; two idle symbols are sent; the held word is lost.
- Random `VALID_IN` over 1000 words, checked against a model -> every accepted word is serialised exactly once, in order, aligned to `SYM_START`.
